// File: rtl/router_pkg.sv
// Shared router definitions: header field widths, framer FSM states and header packing.
package router_pkg;

  localparam int unsigned HDR_ADDR_W = 2;
  localparam int unsigned HDR_LEN_W  = 6;
  localparam logic [HDR_ADDR_W-1:0] ADDR_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    HEADER,
    PAYLOAD,
    PARITY,
    GAP
  } framer_state_t;

  function automatic logic [HDR_LEN_W+HDR_ADDR_W-1:0] pack_header(
    input logic [HDR_ADDR_W-1:0] addr,
    input logic [HDR_LEN_W-1:0]  len
  );
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_pkt_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count; a pop frees a slot
// for a same-cycle push even when full.
module router_pkt_fifo #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= ptr_inc(wptr);
      if (do_pop)  rptr <= ptr_inc(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/router_pkt_framer.sv
// Router input-port packet source: buffers a whole payload, then emits
// header / payload / parity back-to-back under busy back-pressure.
module router_pkt_framer
  import router_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [HDR_ADDR_W-1:0] cmd_addr,
  input  logic [HDR_LEN_W-1:0]  cmd_len,
  input  logic                  cmd_bad_parity,
  input  logic                  pld_valid,
  output logic                  pld_ready,
  input  logic [7:0]            pld_data,
  input  logic                  busy,
  output logic                  packet_valid,
  output logic [7:0]            pkt_data,
  output logic                  err_cmd
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  framer_state_t         state_q, state_d;
  logic [HDR_ADDR_W-1:0] addr_q;
  logic [HDR_LEN_W-1:0]  len_q;
  logic                  bad_q;
  logic [HDR_LEN_W-1:0]  cnt_q, cnt_d;
  logic [7:0]            par_q, par_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  have_q;
  logic                  valid_d;
  logic [7:0]            data_d;
  logic                  err_d;
  logic                  cmd_ready_d;
  logic                  pld_ready_d;

  logic                  cmd_fire;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [7:0]            fifo_head;
  logic [CW-1:0]         fifo_count;
  logic [CW-1:0]         count_next;
  logic                  fifo_full;
  logic                  fifo_empty;

  router_pkt_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk  (clk),
    .rst  (resetn),
    .push (fifo_push),
    .din  (pld_data),
    .pop  (fifo_pop),
    .dout (fifo_head),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign cmd_fire   = cmd_valid & cmd_ready;
  assign fifo_push  = pld_valid & pld_ready & ~fifo_full;
  assign count_next = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    gap_d    = gap_q;
    valid_d  = packet_valid;
    data_d   = pkt_data;
    err_d    = 1'b0;
    fifo_pop = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (cmd_addr == ADDR_ILLEGAL || cmd_len == '0) err_d = 1'b1;
          else                                             state_d = FILL;
        end
      end
      FILL: begin
        if (have_q) begin
          state_d = HEADER;
          data_d  = pack_header(addr_q, len_q);
          par_d   = pack_header(addr_q, len_q);
          cnt_d   = len_q;
          valid_d = 1'b1;
        end
      end
      HEADER: begin
        if (!busy) begin
          fifo_pop = ~fifo_empty;
          data_d   = fifo_head;
          par_d    = par_q ^ fifo_head;
          cnt_d    = cnt_q - 1'b1;
          state_d  = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (!busy) begin
          if (cnt_q == '0) begin
            state_d = PARITY;
            valid_d = 1'b0;
            data_d  = bad_q ? ~par_q : par_q;
          end else begin
            fifo_pop = ~fifo_empty;
            data_d   = fifo_head;
            par_d    = par_q ^ fifo_head;
            cnt_d    = cnt_q - 1'b1;
          end
        end
      end
      PARITY: begin
        if (!busy) begin
          data_d = '0;
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            gap_d   = GW'(GAP_CYCLES - 1);
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    pld_ready_d = (count_next != CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      bad_q        <= 1'b0;
      cnt_q        <= '0;
      par_q        <= '0;
      gap_q        <= '0;
      have_q       <= 1'b0;
      packet_valid <= 1'b0;
      pkt_data     <= '0;
      err_cmd      <= 1'b0;
      cmd_ready    <= 1'b0;
      pld_ready    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cmd_fire) begin
        addr_q <= cmd_addr;
        len_q  <= cmd_len;
        bad_q  <= cmd_bad_parity;
      end
      cnt_q <= cnt_d;
      par_q <= par_d;
      gap_q <= gap_d;
      // Payload-ready compare is registered and only qualified while in FILL,
      // which places the header one cycle after the first FILL cycle.
      have_q       <= (state_q == FILL) && (fifo_count >= CW'(len_q));
      packet_valid <= valid_d;
      pkt_data     <= data_d;
      err_cmd      <= err_d;
      cmd_ready    <= cmd_ready_d;
      pld_ready    <= pld_ready_d;
    end
  end

endmodule

// File: tb/tb_router_pkt_framer.sv
// Scoreboard bench for router_pkt_framer: expected stream built from a payload model
// when commands are issued, drained and compared as the DUT transmits.
module tb_router_pkt_framer;

  localparam int GAP_N = 2;

  typedef struct packed {
    logic       par;
    logic [7:0] b;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_addr;
  logic [5:0] cmd_len;
  logic       cmd_bad_parity;
  logic       pld_valid;
  logic       pld_ready;
  logic [7:0] pld_data;
  logic       busy;
  logic       packet_valid;
  logic [7:0] pkt_data;
  logic       err_cmd;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  logic [7:0] pld_model[$];

  always #5 clk = ~clk;

  router_pkt_framer #(
    .GAP_CYCLES(GAP_N),
    .FIFO_DEPTH(64)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .cmd_bad_parity(cmd_bad_parity),
    .pld_valid     (pld_valid),
    .pld_ready     (pld_ready),
    .pld_data      (pld_data),
    .busy          (busy),
    .packet_valid  (packet_valid),
    .pkt_data      (pkt_data),
    .err_cmd       (err_cmd)
  );

  task automatic push_byte(input logic [7:0] b);
    int t;
    @(posedge clk); #1;
    pld_valid = 1'b1;
    pld_data  = b;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!pld_ready && t < 200);
    if (pld_ready) begin
      @(posedge clk); #1;
      pld_model.push_back(b);
    end else begin
      vectors++;
      miscompares++;
      $display("FAIL pld_handshake: pld_ready=%0b after %0d cycles, want 1", pld_ready, t);
    end
    pld_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] a, input logic [5:0] l, input logic bad);
    int t;
    logic [7:0] p;
    logic [7:0] b;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_addr = a;
    cmd_len = l;
    cmd_bad_parity = bad;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!cmd_ready && t < 200);
    if (cmd_ready) begin
      @(posedge clk); #1;
      if (a != 2'd3 && l != 6'd0) begin
        p = {l, a};
        exp_q.push_back('{par: 1'b0, b: p});
        for (int i = 0; i < int'(l); i++) begin
          b = pld_model.pop_front();
          exp_q.push_back('{par: 1'b0, b: b});
          p = p ^ b;
        end
        exp_q.push_back('{par: 1'b1, b: bad ? ~p : p});
      end
    end else begin
      vectors++;
      miscompares++;
      $display("FAIL cmd_handshake: cmd_ready=%0b after %0d cycles, want 1", cmd_ready, t);
    end
    cmd_valid = 1'b0;
  endtask

  // Drains one expected packet; optionally stalls with busy while byte stall_at is driven.
  task automatic drain_packet(input string name, input int stall_at, input int stall_n,
                              output int waited);
    int   n, stalls, held, budget;
    logic done;
    exp_t e;
    n = 0; stalls = 0; held = 0; budget = 0; waited = 0; done = 1'b0;
    while (!done && budget < 400 && exp_q.size() != 0) begin
      @(negedge clk);
      budget++;
      busy = 1'b0;
      e = exp_q[0];
      if (!e.par && n == 0 && !packet_valid) begin
        waited++;
      end else begin
        vectors++;
        if (packet_valid !== ~e.par || pkt_data !== e.b) begin
          miscompares++;
          $display("FAIL %s byte %0d: got valid=%0b data=0x%02h, want valid=%0b data=0x%02h",
                   name, n, packet_valid, pkt_data, ~e.par, e.b);
        end
        if (n == stall_at) begin
          held++;
          if (stalls < stall_n) begin
            busy = 1'b1;
            stalls++;
          end
        end
        if (!busy) begin
          void'(exp_q.pop_front());
          n++;
          if (e.par) done = 1'b1;
        end
      end
    end
    busy = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: %0d bytes seen, %0d still expected", name, n, exp_q.size());
      exp_q.delete();
    end
    if (stall_at >= 0) begin
      vectors++;
      if (held != stall_n + 1) begin
        miscompares++;
        $display("FAIL %s hold: byte %0d held %0d cycles, want %0d", name, stall_at, held, stall_n + 1);
      end
    end
    for (int g = 0; g < GAP_N; g++) begin
      @(negedge clk);
      vectors++;
      if (packet_valid !== 1'b0 || pkt_data !== 8'h00) begin
        miscompares++;
        $display("FAIL %s gap %0d: got valid=%0b data=0x%02h, want valid=0 data=0x00",
                 name, g, packet_valid, pkt_data);
      end
    end
  endtask

  task automatic test_reset;
    resetn = 1'b1;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_bad_parity = 1'b0;
    pld_valid = 1'b0; pld_data = '0; busy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({packet_valid, pkt_data, err_cmd, cmd_ready, pld_ready} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_values: got valid=%0b data=0x%02h err=%0b cmd_ready=%0b pld_ready=%0b, want all 0",
               packet_valid, pkt_data, err_cmd, cmd_ready, pld_ready);
    end
    resetn = 1'b0;
    @(negedge clk);
    vectors++;
    if ({cmd_ready, pld_ready, packet_valid, err_cmd} !== 4'b1100) begin
      miscompares++;
      $display("FAIL post_reset: got cmd_ready=%0b pld_ready=%0b valid=%0b err=%0b, want 1 1 0 0",
               cmd_ready, pld_ready, packet_valid, err_cmd);
    end
  endtask

  task automatic test_normal;
    int w;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    send_cmd(2'd1, 6'd3, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (packet_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL latency_early_%0d: got valid=%0b, want 0", i, packet_valid);
      end
    end
    drain_packet("normal", -1, 0, w);
    vectors++;
    if (w != 0) begin
      miscompares++;
      $display("FAIL latency: header after %0d extra cycles, want 0", w);
    end
  endtask

  task automatic test_back_pressure;
    int w;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    send_cmd(2'd1, 6'd3, 1'b0);
    drain_packet("back_pressure", 2, 3, w);
  endtask

  task automatic test_illegal;
    logic [1:0] a [2];
    logic [5:0] l [2];
    int w;
    a[0] = 2'd3; l[0] = 6'd5;
    a[1] = 2'd0; l[1] = 6'd0;
    push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3);
    for (int k = 0; k < 2; k++) begin
      send_cmd(a[k], l[k], 1'b0);
      @(negedge clk);
      vectors++;
      if (err_cmd !== 1'b1 || packet_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL illegal_%0d pulse: got err=%0b valid=%0b, want err=1 valid=0", k, err_cmd, packet_valid);
      end
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        vectors++;
        if (err_cmd !== 1'b0 || packet_valid !== 1'b0 || cmd_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL illegal_%0d after %0d: got err=%0b valid=%0b cmd_ready=%0b, want 0 0 1",
                   k, c, err_cmd, packet_valid, cmd_ready);
        end
      end
    end
    send_cmd(2'd0, 6'd3, 1'b0);
    drain_packet("after_illegal", -1, 0, w);
  endtask

  task automatic test_bad_parity;
    int w;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    send_cmd(2'd1, 6'd3, 1'b1);
    drain_packet("bad_parity", -1, 0, w);
  endtask

  task automatic test_boundary;
    int w;
    for (int i = 0; i < 63; i++) push_byte(8'((i * 37 + 5) & 8'hFF));
    @(negedge clk);
    vectors++;
    if (pld_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL fifo_63: got pld_ready=%0b, want 1", pld_ready);
    end
    push_byte(8'h5A);
    @(negedge clk);
    vectors++;
    if (pld_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fifo_full: got pld_ready=%0b, want 0", pld_ready);
    end
    send_cmd(2'd2, 6'd63, 1'b0);
    drain_packet("boundary", -1, 0, w);
    vectors++;
    if (pld_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL fifo_drained: got pld_ready=%0b, want 1", pld_ready);
    end
  endtask

  task automatic test_reset_mid;
    int t;
    int w;
    for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i));
    send_cmd(2'd1, 6'd5, 1'b0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!packet_valid && t < 50);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    vectors++;
    if ({packet_valid, pkt_data, err_cmd, cmd_ready, pld_ready} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_mid: got valid=%0b data=0x%02h err=%0b cmd_ready=%0b pld_ready=%0b, want all 0",
               packet_valid, pkt_data, err_cmd, cmd_ready, pld_ready);
    end
    exp_q.delete();
    pld_model.delete();
    resetn = 1'b0;
    @(negedge clk);
    push_byte(8'h77); push_byte(8'h88);
    send_cmd(2'd2, 6'd2, 1'b0);
    drain_packet("after_reset", -1, 0, w);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_back_pressure();
    test_illegal();
    test_bad_parity();
    test_boundary();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/router_pkt_framer.md
# router_pkt_framer

Upstream packet source for `router_top`. Accepts a packet command (destination, length) and a stream of payload bytes, and buffers the whole payload. It then drives the router input port as a gap-free packet: a header byte, the payload, and a trailing parity byte, obeying the router's `busy` back-pressure. It also provides a deliberate parity-corruption hook so benches can exercise the router `err` path.

## Interface
- `GAP_CYCLES`, 2: idle cycles (`packet_valid`=0, `pkt_data`=0) after each parity byte before the next header.
- `FIFO_DEPTH`, 64: payload buffer depth in bytes. Must be ≥ 63.
- `clk`  input  1  rising-edge clock.
- `resetn`  input  1  reset, synchronous, active-high (1 = reset).
- `cmd_valid`  input  1  command offered.
- `cmd_ready`  output  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_addr`  input  2  destination port 0..2. Value 3 is illegal.
- `cmd_len`  input  6  payload length 1..63. Value 0 is illegal.
- `cmd_bad_parity`  input  1  when 1, the transmitted parity byte is inverted.
- `pld_valid`  input  1  payload byte offered.
- `pld_ready`  output  1  payload byte accepted when `pld_valid & pld_ready`.
- `pld_data`  input  8  payload byte.
- `busy`  input  1  router back-pressure.
- `packet_valid`  output  1  drives router `packet_valid`.
- `pkt_data`  output  8  drives router `datain`.
- `err_cmd`  output  1  one-cycle pulse when an illegal command is rejected.

## Operation
- FSM states: IDLE, FILL, HEADER, PAYLOAD, PARITY, GAP.
- IDLE: `cmd_ready`=1. On handshake, latch addr, len and bad_parity.
  - Illegal command (addr=3 or len=0): pulse `err_cmd` next cycle and stay in IDLE. FIFO is untouched.
  - Legal command: go to FILL.
- FILL: wait until FIFO count ≥ len, then load the header and go to HEADER. A packet never starts until its whole payload is buffered, so there are no mid-packet bubbles.
- Header byte = {len[5:0], addr[1:0]}. Parity accumulator is initialised to the header value.
- HEADER / PAYLOAD: `packet_valid`=1. On each rising edge with `busy`=0, the current byte is consumed. The next byte is then loaded: the FIFO head is popped, XORed into parity, and the byte counter is decremented.
- After the last payload byte is consumed, go to PARITY. In PARITY, `packet_valid`=0 and `pkt_data` = parity, or ~parity if bad_parity is set.
- The parity byte is consumed on the first edge with `busy`=0. Then go to GAP for `GAP_CYCLES` cycles, then IDLE. If `GAP_CYCLES`=0, go straight to IDLE.
- `pld_ready` = FIFO not full, in every state, so payload can be prefetched.
- Push and pop in the same cycle are allowed, including when the FIFO is full (pop frees the slot). The count stays unchanged in that case.
- Payload bytes beyond `len` stay in the FIFO for the next packet.

## Timing
- Reset values: `packet_valid`=0, `pkt_data`=0, `err_cmd`=0, `cmd_ready`=0, `pld_ready`=0.
  - `cmd_ready`=1 and `pld_ready`=1 from the first cycle after reset deasserts.
  - Reset flushes the FIFO and clears the FSM.
- Reset mid-packet: outputs take their reset values at the next edge, and the packet is abandoned.
- All outputs are registered.
- Latency: command accepted at edge T with payload already buffered → header visible after edge T+2.
- While `busy`=1, `pkt_data` and `packet_valid` hold stable. A byte counts as transferred at each edge where it is driven and `busy`=0.
- Unstalled throughput: one byte per cycle. A packet occupies len+2 cycles, plus `GAP_CYCLES`.
- Counters: byte counter 6 bits, FIFO count $clog2(FIFO_DEPTH)+1 bits, pointers wrap modulo `FIFO_DEPTH`.

## Structure
- Package `router_pkg`: FSM state enum, `HDR_ADDR_W`=2, `HDR_LEN_W`=6, `ADDR_ILLEGAL`=2'd3, and a header-packing function. Shared with the router and its bench.
- Sub-module `router_pkt_fifo`: synchronous single-clock FIFO, parameterised depth and width, with count, full and empty outputs.
- The top level holds the FSM, command latch, byte counter and parity accumulator.

## Test plan
- Normal packet: addr=1, len=3, payload 0x11,0x22,0x33, `busy`=0 → output sequence 0x0D, 0x11, 0x22, 0x33 with `packet_valid`=1, then parity 0x0D with `packet_valid`=0, then 2 idle cycles.
- Back-pressure: same packet with `busy`=1 for 3 cycles while 0x22 is driven → 0x22 held for 4 cycles, and the sequence and parity are unchanged.
- Illegal commands: addr=3, len=5 → `err_cmd` pulses one cycle and no `packet_valid`. Likewise addr=0, len=0 → `err_cmd` pulses.
- Parity corruption: normal packet with `cmd_bad_parity`=1 → parity byte 0xF2.
- Boundary: addr=2, len=63, with 63 bytes prefetched before the command → header 0xFE and 63 back-to-back bytes. `pld_ready`=0 only if the FIFO reaches `FIFO_DEPTH`.
- Reset mid-packet: assert `resetn` during PAYLOAD → next edge gives `packet_valid`=0, `pkt_data`=0, FIFO empty. A following command works normally.
